// File: rtl/shift_frame_ctrl.sv
// rtl/shift_frame_ctrl.sv - serial-in/parallel-out frame sequencing controller
//
// Purpose: accepts a frame length, takes serial bits over a valid/ready
// handshake into an internal shift register, and presents the assembled
// word on a valid/ready output handshake.
//
// Ports:
//   clk_i, reset_n_i       clock (rising edge), asynchronous active-low reset
//   start_i, len_i         frame request and its length in bits (1..width_p)
//   abort_i                cancel any frame in progress
//   serial_i, serial_v_i   serial bit and its valid
//   serial_ready_o         a serial bit is accepted this cycle when valid
//   data_o, v_o, ready_i   assembled word, word valid, consumer accept
//   busy_o                 controller not idle
//   shift_en_o             shift enable applied this cycle
//   count_o                bits accepted in the current frame
//   err_o                  one-cycle pulse after an illegal start
module shift_frame_ctrl #(
  parameter int width_p = 8,
  parameter int lenw_p  = $clog2(width_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic [lenw_p-1:0]   len_i,
  input  logic                abort_i,
  input  logic                serial_i,
  input  logic                serial_v_i,
  output logic                serial_ready_o,
  output logic [width_p-1:0]  data_o,
  output logic                v_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                shift_en_o,
  output logic [lenw_p-1:0]   count_o,
  output logic                err_o
);

  localparam logic [lenw_p-1:0] WidthL = lenw_p'(width_p);
  localparam logic [lenw_p-1:0] OneL   = lenw_p'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [lenw_p-1:0]   count_q, count_d;
  logic [lenw_p-1:0]   len_q, len_d;
  logic                err_q, err_d;
  logic                len_legal;
  logic [lenw_p-1:0]   count_inc;

  assign len_legal = (len_i != '0) && (len_i <= WidthL);
  assign count_inc = count_q + OneL;

  // Abort withdraws ready so a bit offered in the abort cycle is never shifted.
  assign serial_ready_o = (state_q == ST_SHIFT) && !abort_i;
  assign shift_en_o     = serial_v_i && serial_ready_o;

  assign v_o     = (state_q == ST_HOLD);
  assign busy_o  = (state_q != ST_IDLE);
  assign data_o  = data_q;
  assign count_o = count_q;
  assign err_o   = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    len_d   = len_q;
    err_d   = 1'b0;

    if (abort_i) begin
      // Data is deliberately left as-is so a partial word stays observable.
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_legal) begin
              len_d   = len_i;
              data_d  = '0;
              count_d = '0;
              state_d = ST_SHIFT;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (shift_en_o) begin
            // Shifting left from a cleared register lands the first bit at
            // data[len-1] once len bits are in, with upper bits still zero.
            data_d  = {data_q[width_p-2:0], serial_i};
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (ready_i) begin
            count_d = '0;
            state_d = ST_IDLE;
            if (start_i) begin
              if (len_legal) begin
                len_d   = len_i;
                data_d  = '0;
                state_d = ST_SHIFT;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
- Sequencing controller for the serial-in/parallel-out shift register datapath.
- Accepts a frame length, gates the per-bit shift enable from a serial valid/ready handshake, and counts accepted bits.
- Presents the assembled parallel word on a valid/ready output handshake.
- Sits between a serial link front-end and any parallel consumer; owns an internal width_p-bit shift register with the same shift order as the team's shift block.

Parameters:
width_p, 8, parallel word width and maximum frame length in bits; legal range 2..32.
lenw_p, $clog2(width_p+1), width of len_i and count_o; derived, not overridden.

Ports:
clk_i  input  1  single clock, rising-edge.
reset_n_i  input  1  asynchronous, active-low reset.
start_i  input  1  request a new frame; sampled in IDLE, and in HOLD together with ready_i.
len_i  input  lenw_p  frame length in bits, sampled with start_i.
abort_i  input  1  cancel any frame in progress.
serial_i  input  1  serial data bit.
serial_v_i  input  1  serial bit valid.
serial_ready_o  output  1  controller will accept a serial bit this cycle.
data_o  output  width_p  assembled parallel word.
v_o  output  1  data_o holds a complete frame.
ready_i  input  1  consumer accepts data_o.
busy_o  output  1  state is not IDLE.
shift_en_o  output  1  serial_v_i & serial_ready_o; the shift enable applied this cycle.
count_o  output  lenw_p  bits accepted in the current frame.
err_o  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (reset_n_i low, asynchronous, takes effect immediately):
  - State IDLE; data_o=0, count_o=0, v_o=0, err_o=0, serial_ready_o=0, busy_o=0.
  - Released synchronously on the first rising edge with reset_n_i high.
- States: IDLE, SHIFT, HOLD; all outputs are registered or decoded from state.
- IDLE:
  - start_i with 1<=len_i<=width_p: latch len, clear data to 0, clear count, go to SHIFT next cycle.
  - start_i with len_i==0 or len_i>width_p: stay in IDLE and pulse err_o high for exactly one cycle, the cycle after start_i.
- SHIFT:
  - serial_ready_o=1.
  - Each cycle with serial_v_i=1: data <= {data[width_p-2:0], serial_i}; count_o increments.
  - The first bit received ends at data_o[len-1] and the last at data_o[0]; bits above len-1 stay 0.
  - When the accepted bit makes count == len, go to HOLD next cycle; v_o rises that same edge, with latency one cycle after the last accepted bit.
  - start_i is ignored in SHIFT.
- HOLD:
  - v_o=1, serial_ready_o=0; data_o and count_o are held stable while ready_i is low, for any duration.
  - ready_i=1: the word is consumed; go to IDLE next cycle with v_o=0; data_o keeps its value, count_o clears.
  - ready_i=1 and start_i=1 with a legal len_i: go directly to SHIFT, clearing data and count (back-to-back frames).
  - ready_i=1 and start_i=1 with an illegal len_i: go to IDLE and pulse err_o.
- abort_i (any state, highest priority after reset):
  - Next state IDLE; v_o=0, count_o=0, data_o unchanged.
  - Any bit offered in the same cycle is not shifted; shift_en_o=0 that cycle.
- Edge cases:
  - len=1 frames go SHIFT -> HOLD after a single accepted bit.
  - serial_v_i gaps of any length in SHIFT are legal.
- Counting: count_o never exceeds len and never wraps.
- Ignored inputs: serial_v_i outside SHIFT is ignored, with no shift and no error.

Test Plan:
1. width_p=8; start len=8; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> v_o high the cycle after the 8th bit; data_o=8'hB2; count_o=8; shift_en_o high for exactly 8 cycles.
2. start len=3; bits 1,1,0 with serial_v_i gaps of 2 cycles between bits -> data_o=8'h06; v_o after the 3rd accepted bit; count_o holds during gaps.
3. In HOLD, hold ready_i low for 5 cycles while driving serial_v_i=1 -> data_o stable, serial_ready_o=0, shift_en_o=0; ready_i high -> IDLE, v_o=0 next cycle.
4. start with len=0, then with len=9 -> err_o single-cycle pulse each time; busy_o stays 0; data_o unchanged.
5. Stop after 4 of 8 bits:
   - abort_i -> IDLE next cycle, v_o never rises, count_o=0.
   - Repeat, but drop reset_n_i mid-SHIFT between clock edges -> all outputs 0 immediately.
6. Back-to-back: ready_i=1 and start_i=1 with len=2 in HOLD -> SHIFT next cycle with data cleared; bits 1,1 -> data_o=8'h03, v_o high.
